deferred_step_aggregator: RTL and testbench

//   Multi-channel successor of the deferred-result/step control block.
//   - Collects per-core commit step counts and batches them into coalesced host
//     "nstep" requests.
//   - Flush triggers: count threshold, idle timeout, or explicit request.
//   - Requests leave on a valid/ready channel to the host bridge.
//   - Latches the host's deferred result code and returns it to the testbench.
//   - Sits between the per-core difftest step outputs and the DPI/transactor bridge.
//

---
 rtl/deferred_step_aggregator.sv | 195 +++++++++++++++++++
 tb/tb_deferred_step_aggregator.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/deferred_step_aggregator.sv
// deferred_step_aggregator
// Collects per-core commit step counts into coalesced host "nstep" batches.
// A batch is flushed on count threshold, idle timeout or an explicit request,
// and it is offered to the host bridge on a valid/ready channel. The block also
// latches the host's deferred result code.
//
// Handshake: nstep_valid rises only with a complete batch. Once raised, it stays
// high with nstep_count and nstep_mask frozen until a cycle where nstep_valid and
// nstep_ready are both high. That cycle is the transfer. nstep_ready may toggle
// freely, and it is ignored while nstep_valid is low.
module deferred_step_aggregator #(
  parameter int              NUM_CH         = 4,
  parameter int              STEP_W         = 8,
  parameter int              ACC_W          = 32,
  parameter longint unsigned FLUSH_THRESH   = 64,
  parameter int unsigned     TIMEOUT        = 256,
  parameter bit              STICKY_RESULT  = 1'b1,
  parameter bit              STOP_ON_RESULT = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_CH*STEP_W-1:0] step,
  input  logic                     flush_req,
  output logic                     nstep_valid,
  input  logic                     nstep_ready,
  output logic [ACC_W-1:0]         nstep_count,
  output logic [NUM_CH-1:0]        nstep_mask,
  input  logic                     result_valid,
  input  logic [7:0]               result_code,
  output logic [7:0]               simv_result,
  output logic                     result_sticky,
  output logic                     overflow_err,
  output logic [1:0]               fsm_state
);

  // A per-cycle sum of all channels never overflows this width.
  localparam int SUM_W  = STEP_W + $clog2(NUM_CH);
  // The additions are one bit wider than either operand, so saturation is a plain compare.
  localparam int WIDE_W = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;
  // The timer only has to count 0 .. TIMEOUT-1.
  localparam int TMR_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [ACC_W-1:0] ACC_MAX  = {ACC_W{1'b1}};
  localparam logic [ACC_W-1:0] THRESH_V = ACC_W'(FLUSH_THRESH);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_OFFER = 2'd2
  } state_t;

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [NUM_CH-1:0]  mask;
  logic [ACC_W-1:0]   spare;
  logic [NUM_CH-1:0]  spare_mask;
  logic [TMR_W-1:0]   timer;

  logic [SUM_W-1:0]   step_sum;
  logic [NUM_CH-1:0]  step_bits;
  logic               take_steps;
  logic [SUM_W-1:0]   eff_sum;
  logic [NUM_CH-1:0]  eff_bits;

  logic [WIDE_W-1:0]  acc_wide;
  logic               acc_sat_hit;
  logic [ACC_W-1:0]   nacc;
  logic [WIDE_W-1:0]  spare_wide;
  logic               spare_sat_hit;
  logic [ACC_W-1:0]   spare_nacc;

  logic               thresh_hit;
  logic               timeout_hit;

  assign fsm_state = state;

  // Sum the channel step counts and note which channels committed this cycle.
  always_comb begin
    step_sum  = '0;
    step_bits = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      step_sum     = step_sum + SUM_W'(step[i*STEP_W +: STEP_W]);
      step_bits[i] = |step[i*STEP_W +: STEP_W];
    end
  end

  // After a nonzero result the simulation is finishing, so new commits are dropped.
  assign take_steps = !(STOP_ON_RESULT && result_sticky);
  assign eff_sum    = take_steps ? step_sum  : '0;
  assign eff_bits   = take_steps ? step_bits : '0;

  // The primary accumulator is always zero in IDLE, so this adder also gives the
  // first value of a new batch.
  always_comb begin
    acc_wide    = WIDE_W'(acc) + WIDE_W'(eff_sum);
    acc_sat_hit = (acc_wide > WIDE_W'(ACC_MAX));
    nacc        = acc_sat_hit ? ACC_MAX : acc_wide[ACC_W-1:0];
  end

  // The spare accumulator collects steps while a batch is waiting for the host.
  always_comb begin
    spare_wide    = WIDE_W'(spare) + WIDE_W'(eff_sum);
    spare_sat_hit = (spare_wide > WIDE_W'(ACC_MAX));
    spare_nacc    = spare_sat_hit ? ACC_MAX : spare_wide[ACC_W-1:0];
  end

  assign thresh_hit  = (nacc >= THRESH_V);
  assign timeout_hit = (TIMEOUT != 0) && (timer == TMR_LAST);

  // Batch FSM: it accumulates, decides to flush, and holds the offered batch until it is accepted.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      acc          <= '0;
      mask         <= '0;
      spare        <= '0;
      spare_mask   <= '0;
      timer        <= '0;
      nstep_valid  <= 1'b0;
      nstep_count  <= '0;
      nstep_mask   <= '0;
      overflow_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (eff_sum != '0) begin
            if (acc_sat_hit) overflow_err <= 1'b1;
            timer <= '0;
            if (thresh_hit || flush_req) begin
              state       <= S_OFFER;
              nstep_valid <= 1'b1;
              nstep_count <= nacc;
              nstep_mask  <= eff_bits;
            end else begin
              state <= S_ACCUM;
              acc   <= nacc;
              mask  <= eff_bits;
            end
          end
        end

        S_ACCUM: begin
          if (acc_sat_hit) overflow_err <= 1'b1;
          timer <= timer + 1'b1;
          if (thresh_hit || timeout_hit || flush_req) begin
            state       <= S_OFFER;
            nstep_valid <= 1'b1;
            nstep_count <= nacc;
            nstep_mask  <= mask | eff_bits;
            acc         <= '0;
            mask        <= '0;
          end else begin
            acc  <= nacc;
            mask <= mask | eff_bits;
          end
        end

        S_OFFER: begin
          if (spare_sat_hit) overflow_err <= 1'b1;
          if (nstep_ready) begin
            // Whatever arrived while the batch was waiting becomes the next batch.
            nstep_valid <= 1'b0;
            acc         <= spare_nacc;
            mask        <= spare_mask | eff_bits;
            spare       <= '0;
            spare_mask  <= '0;
            timer       <= '0;
            state       <= (spare_nacc != '0) ? S_ACCUM : S_IDLE;
          end else begin
            spare      <= spare_nacc;
            spare_mask <= spare_mask | eff_bits;
          end
        end

        default: begin
          state       <= S_IDLE;
          nstep_valid <= 1'b0;
        end
      endcase
    end
  end

  // Deferred result latch. In sticky mode the first nonzero code is frozen.
  always_ff @(posedge clock) begin
    if (reset) begin
      simv_result   <= 8'd0;
      result_sticky <= 1'b0;
    end else if (result_valid && (!STICKY_RESULT || !result_sticky)) begin
      simv_result <= result_code;
      if (result_code != 8'd0) result_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_deferred_step_aggregator.sv
// Bench for deferred_step_aggregator.
// Two instances share the same stimulus:
//   u0: ACC_W=32, THRESH=64, TIMEOUT=8, sticky result, stop on result.
//   u1: ACC_W=8, THRESH=255, TIMEOUT=5, last-write result, steps never stopped.
// The bench runs a vector table, directed corner sequences, and random traffic
// checked against a batch-level reference model with an expected-batch queue.
module tb_deferred_step_aggregator;

  logic        clock;
  logic        reset;
  logic [31:0] step;
  logic        flush_req;
  logic        nstep_ready;
  logic        result_valid;
  logic [7:0]  result_code;

  logic        v0, v1;
  logic [31:0] cnt0;
  logic [7:0]  cnt1;
  logic [3:0]  msk0, msk1;
  logic [7:0]  res0, res1;
  logic        stk0, stk1, ovf0, ovf1;
  logic [1:0]  st0, st1;

  int checks   = 0;
  int failures = 0;

  // Expected batches {count[31:0], mask[3:0]}, one queue per instance.
  logic [35:0] exp_q0[$];
  logic [35:0] exp_q1[$];

  deferred_step_aggregator #(
    .NUM_CH(4), .STEP_W(8), .ACC_W(32), .FLUSH_THRESH(64), .TIMEOUT(8),
    .STICKY_RESULT(1'b1), .STOP_ON_RESULT(1'b1)
  ) u0 (
    .clock(clock), .reset(reset), .step(step), .flush_req(flush_req),
    .nstep_valid(v0), .nstep_ready(nstep_ready), .nstep_count(cnt0),
    .nstep_mask(msk0), .result_valid(result_valid), .result_code(result_code),
    .simv_result(res0), .result_sticky(stk0), .overflow_err(ovf0), .fsm_state(st0)
  );

  deferred_step_aggregator #(
    .NUM_CH(4), .STEP_W(8), .ACC_W(8), .FLUSH_THRESH(255), .TIMEOUT(5),
    .STICKY_RESULT(1'b0), .STOP_ON_RESULT(1'b0)
  ) u1 (
    .clock(clock), .reset(reset), .step(step), .flush_req(flush_req),
    .nstep_valid(v1), .nstep_ready(nstep_ready), .nstep_count(cnt1),
    .nstep_mask(msk1), .result_valid(result_valid), .result_code(result_code),
    .simv_result(res1), .result_sticky(stk1), .overflow_err(ovf1), .fsm_state(st1)
  );

  // Clock and the initial reset level.
  initial begin
    clock = 1'b0;
    reset = 1'b1;
    step = '0;
    flush_req = 1'b0;
    nstep_ready = 1'b0;
    result_valid = 1'b0;
    result_code = '0;
  end
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  function automatic int cfg_accw(input int k);   return (k == 0) ? 32 : 8;   endfunction
  function automatic longint cfg_thr(input int k); return (k == 0) ? 64 : 255; endfunction
  function automatic int cfg_to(input int k);     return (k == 0) ? 8 : 5;    endfunction
  function automatic bit cfg_stk(input int k);    return (k == 0);            endfunction
  function automatic bit cfg_stop(input int k);   return (k == 0);            endfunction

  bit         m_open[2];
  longint     m_acc[2];
  logic [3:0] m_msk[2];
  int         m_age[2];
  bit         m_off[2];
  longint     m_ocnt[2];
  logic [3:0] m_omsk[2];
  longint     m_spare[2];
  logic [3:0] m_smsk[2];
  logic [7:0] m_res[2];
  bit         m_stk[2];
  bit         m_ovf[2];

  task automatic close_batch(input int k, input longint n, input logic [3:0] m);
    logic [35:0] e;
    logic [63:0] nv;
    nv = n;
    e = {nv[31:0], m};
    m_off[k]  = 1'b1;
    m_ocnt[k] = n;
    m_omsk[k] = m;
    m_open[k] = 1'b0;
    if (k == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  task automatic model_step(input int k, input logic rst, input logic [31:0] st,
                            input logic fl, input logic rdy, input logic rv,
                            input logic [7:0] rc);
    longint mx, s, n;
    logic [3:0] bits;
    if (rst) begin
      m_open[k] = 0; m_acc[k] = 0; m_msk[k] = 0; m_age[k] = 0;
      m_off[k] = 0; m_ocnt[k] = 0; m_omsk[k] = 0; m_spare[k] = 0; m_smsk[k] = 0;
      m_res[k] = 0; m_stk[k] = 0; m_ovf[k] = 0;
      if (k == 0) exp_q0.delete();
      else        exp_q1.delete();
      return;
    end
    mx = (longint'(1) << cfg_accw(k)) - 1;
    s = 0;
    bits = 0;
    for (int c = 0; c < 4; c++) begin
      s = s + longint'(st[c*8 +: 8]);
      bits[c] = (st[c*8 +: 8] != 0);
    end
    if (cfg_stop(k) && m_stk[k]) begin
      s = 0;
      bits = 0;
    end
    if (m_off[k]) begin
      n = m_spare[k] + s;
      if (n > mx) begin n = mx; m_ovf[k] = 1; end
      if (rdy) begin
        m_off[k] = 0;
        if (n != 0) begin
          m_open[k] = 1; m_acc[k] = n; m_msk[k] = m_smsk[k] | bits; m_age[k] = 0;
        end else begin
          m_open[k] = 0;
        end
        m_spare[k] = 0;
        m_smsk[k] = 0;
      end else begin
        m_spare[k] = n;
        m_smsk[k] = m_smsk[k] | bits;
      end
    end else if (m_open[k]) begin
      n = m_acc[k] + s;
      if (n > mx) begin n = mx; m_ovf[k] = 1; end
      if (n >= cfg_thr(k) || (cfg_to(k) != 0 && m_age[k] == cfg_to(k) - 1) || fl)
        close_batch(k, n, m_msk[k] | bits);
      else begin
        m_acc[k] = n; m_msk[k] = m_msk[k] | bits; m_age[k]++;
      end
    end else if (s != 0) begin
      n = s;
      if (n > mx) begin n = mx; m_ovf[k] = 1; end
      if (n >= cfg_thr(k) || fl) close_batch(k, n, bits);
      else begin
        m_open[k] = 1; m_acc[k] = n; m_msk[k] = bits; m_age[k] = 0;
      end
    end
    if (rv && (!cfg_stk(k) || !m_stk[k])) begin
      m_res[k] = rc;
      if (rc != 0) m_stk[k] = 1;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every DUT transfer must match the oldest batch the model closed.
  task automatic sb_pop(input int k, input logic [31:0] act_c, input logic [3:0] act_m);
    logic [35:0] e;
    int sz;
    sz = (k == 0) ? exp_q0.size() : exp_q1.size();
    if (sz == 0) begin
      chk($sformatf("u%0d_sb_unexpected_batch", k), 64'd1, 64'd0);
    end else begin
      e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      chk($sformatf("u%0d_sb_count", k), act_c, e[35:4]);
      chk($sformatf("u%0d_sb_mask", k), act_m, e[3:0]);
    end
  endtask

  task automatic cmp_inst(input int k, input logic v, input logic [31:0] c,
                          input logic [3:0] m, input logic [7:0] r,
                          input logic s, input logic o);
    logic [63:0] oc;
    oc = m_ocnt[k];
    chk($sformatf("u%0d_valid", k), v, m_off[k]);
    if (m_off[k]) begin
      chk($sformatf("u%0d_count", k), c, oc[31:0]);
      chk($sformatf("u%0d_mask", k), m, m_omsk[k]);
    end
    chk($sformatf("u%0d_result", k), r, m_res[k]);
    chk($sformatf("u%0d_sticky", k), s, m_stk[k]);
    chk($sformatf("u%0d_overflow", k), o, m_ovf[k]);
  endtask

  // Driver: apply one cycle of inputs, advance the model, and compare after the edge.
  task automatic drive_cycle(input logic rst_i, input logic [31:0] st, input logic fl,
                             input logic rdy, input logic rv, input logic [7:0] rc);
    reset = rst_i;
    step = st;
    flush_req = fl;
    nstep_ready = rdy;
    result_valid = rv;
    result_code = rc;
    if (!rst_i && v0 && rdy) sb_pop(0, cnt0, msk0);
    if (!rst_i && v1 && rdy) sb_pop(1, {24'd0, cnt1}, msk1);
    model_step(0, rst_i, st, fl, rdy, rv, rc);
    model_step(1, rst_i, st, fl, rdy, rv, rc);
    @(posedge clock);
    #1;
    cmp_inst(0, v0, cnt0, msk0, res0, stk0, ovf0);
    cmp_inst(1, v1, {24'd0, cnt1}, msk1, res1, stk1, ovf1);
  endtask

  task automatic idle_cycle(input logic rdy);
    drive_cycle(1'b0, 32'd0, 1'b0, rdy, 1'b0, 8'd0);
  endtask

  task automatic check_reset_state();
    chk("rst_u0_valid", v0, 1'b0);
    chk("rst_u0_count", cnt0, 32'd0);
    chk("rst_u0_mask", msk0, 4'd0);
    chk("rst_u0_result", res0, 8'd0);
    chk("rst_u0_sticky", stk0, 1'b0);
    chk("rst_u0_overflow", ovf0, 1'b0);
    chk("rst_u1_valid", v1, 1'b0);
    chk("rst_u1_result", res1, 8'd0);
    chk("rst_u1_overflow", ovf1, 1'b0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] step;
    logic        flush;
    logic        ready;
    logic        rv;
    logic [7:0]  rc;
    logic        e_valid;
    logic [31:0] e_count;
    logic [3:0]  e_mask;
    logic [7:0]  e_res;
    logic        e_sticky;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] st, input logic fl, input logic rdy,
                              input logic rv, input logic [7:0] rc, input logic ev,
                              input logic [31:0] ec, input logic [3:0] em,
                              input logic [7:0] er, input logic es);
    vec_t v;
    v.step = st; v.flush = fl; v.ready = rdy; v.rv = rv; v.rc = rc;
    v.e_valid = ev; v.e_count = ec; v.e_mask = em; v.e_res = er; v.e_sticky = es;
    return v;
  endfunction

  vec_t tbl[10];

  initial begin
    // Four cycles of 4 steps on every channel reach 64. Then the batch is held,
    // accepted, the result is latched, and later steps and flushes are dropped.
    tbl[0] = mk(32'h04040404, 0, 0, 0, 8'h00, 0, 32'd0,  4'h0, 8'h00, 0);
    tbl[1] = mk(32'h04040404, 0, 0, 0, 8'h00, 0, 32'd0,  4'h0, 8'h00, 0);
    tbl[2] = mk(32'h04040404, 0, 0, 0, 8'h00, 0, 32'd0,  4'h0, 8'h00, 0);
    tbl[3] = mk(32'h04040404, 0, 0, 0, 8'h00, 1, 32'd64, 4'hF, 8'h00, 0);
    tbl[4] = mk(32'h00000000, 0, 0, 0, 8'h00, 1, 32'd64, 4'hF, 8'h00, 0);
    tbl[5] = mk(32'h00000000, 0, 1, 0, 8'h00, 0, 32'd0,  4'h0, 8'h00, 0);
    tbl[6] = mk(32'h00000000, 0, 0, 1, 8'h05, 0, 32'd0,  4'h0, 8'h05, 1);
    tbl[7] = mk(32'h00000000, 0, 0, 1, 8'h09, 0, 32'd0,  4'h0, 8'h05, 1);
    tbl[8] = mk(32'h04040404, 0, 0, 0, 8'h00, 0, 32'd0,  4'h0, 8'h05, 1);
    tbl[9] = mk(32'h00000000, 1, 0, 0, 8'h00, 0, 32'd0,  4'h0, 8'h05, 1);

    drive_cycle(1'b1, 32'd0, 0, 0, 0, 8'd0);
    drive_cycle(1'b1, 32'd0, 0, 0, 0, 8'd0);
    check_reset_state();

    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b0, tbl[i].step, tbl[i].flush, tbl[i].ready, tbl[i].rv, tbl[i].rc);
      chk($sformatf("tbl%0d_valid", i), v0, tbl[i].e_valid);
      if (tbl[i].e_valid) begin
        chk($sformatf("tbl%0d_count", i), cnt0, tbl[i].e_count);
        chk($sformatf("tbl%0d_mask", i), msk0, tbl[i].e_mask);
      end
      chk($sformatf("tbl%0d_result", i), res0, tbl[i].e_res);
      chk($sformatf("tbl%0d_sticky", i), stk0, tbl[i].e_sticky);
    end
    // u1 takes the last write.
    chk("last_write_result", res1, 8'h09);
    chk("last_write_sticky", stk1, 1'b1);

    // A single step of 3 on ch2 is flushed by the timeout, 8 cycles after ACCUM is entered.
    drive_cycle(1'b1, 32'd0, 0, 0, 0, 8'd0);
    check_reset_state();
    drive_cycle(1'b0, 32'h00030000, 0, 0, 0, 8'd0);
    for (int i = 1; i < 8; i++) begin
      idle_cycle(1'b0);
      chk($sformatf("timeout_wait%0d", i), v0, 1'b0);
    end
    idle_cycle(1'b0);
    chk("timeout_valid", v0, 1'b1);
    chk("timeout_count", cnt0, 32'd3);
    chk("timeout_mask", msk0, 4'b0100);

    // Backpressure: the offered count stays frozen while ch0 keeps stepping.
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b0, 32'h00000001, 0, 0, 0, 8'd0);
      chk($sformatf("hold%0d_valid", i), v0, 1'b1);
      chk($sformatf("hold%0d_count", i), cnt0, 32'd3);
    end
    drive_cycle(1'b0, 32'h00000001, 0, 1, 0, 8'd0);
    chk("accept_valid_low", v0, 1'b0);
    drive_cycle(1'b0, 32'd0, 1, 0, 0, 8'd0);
    chk("spare_valid", v0, 1'b1);
    chk("spare_count", cnt0, 32'd11);
    chk("spare_mask", msk0, 4'b0001);
    idle_cycle(1'b1);

    // Saturation on the 8-bit instance: 200 + 100 clamps to 255.
    drive_cycle(1'b1, 32'd0, 0, 0, 0, 8'd0);
    drive_cycle(1'b0, 32'd200, 0, 0, 0, 8'd0);
    drive_cycle(1'b0, 32'd100, 0, 0, 0, 8'd0);
    chk("sat_valid", v1, 1'b1);
    chk("sat_count", cnt1, 8'd255);
    chk("sat_overflow", ovf1, 1'b1);

    // Reset during OFFER together with a result write. Reset wins, and the next step starts fresh.
    drive_cycle(1'b1, 32'd0, 0, 0, 1, 8'h07);
    chk("rst_offer_u1_valid", v1, 1'b0);
    chk("rst_offer_u0_valid", v0, 1'b0);
    chk("rst_offer_result", res0, 8'h00);
    chk("rst_offer_overflow", ovf1, 1'b0);
    drive_cycle(1'b0, 32'd1, 1, 0, 0, 8'd0);
    chk("fresh_u1_valid", v1, 1'b1);
    chk("fresh_u1_count", cnt1, 8'd1);
    chk("fresh_u0_count", cnt0, 32'd1);
    chk("fresh_u0_mask", msk0, 4'b0001);
    idle_cycle(1'b1);

    // Random traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] st;
      logic [7:0]  rc;
      logic        rv;
      st = '0;
      for (int c = 0; c < 4; c++) begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 50)      st[c*8 +: 8] = 8'd0;
        else if (r < 90) st[c*8 +: 8] = 8'($urandom_range(1, 8));
        else             st[c*8 +: 8] = 8'($urandom_range(0, 255));
      end
      rv = ($urandom_range(0, 149) == 0);
      rc = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      drive_cycle($urandom_range(0, 199) == 0, st, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) < 7, rv, rc);
    end

    // Drain everything still in flight, then no expected batch may remain.
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, 32'd0, 1, 1, 0, 8'd0);
    chk("drain_u0_queue", exp_q0.size(), 0);
    chk("drain_u1_queue", exp_q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
